// File: rtl/matrix_stream_pkg.sv
// ----------------------------------------------------------------------------
// matrix_stream_pkg
// Shared types and sizing helpers for the parallel-matrix to narrow-stream
// path (serializer and its matching deserializer).
//   state_t    : two-state stream controller encoding (IDLE, SEND)
//   num_beats  : number of output beats needed to carry one N x K matrix
//   cnt_width  : width of a beat counter, never less than one bit
// ----------------------------------------------------------------------------
package matrix_stream_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   function automatic int num_beats(input int n, input int k, input int beat_size);
      return (n * k) / beat_size;
   endfunction

   function automatic int cnt_width(input int beats);
      return (beats > 32'sd1) ? $clog2(beats) : 32'sd1;
   endfunction

endpackage

// File: rtl/matrix_stream_serializer_beat_mux.sv
// ----------------------------------------------------------------------------
// serializer_beat_mux
// Purely combinational selector: picks the BEAT_SIZE consecutive row-major
// elements starting at element i_count*BEAT_SIZE out of a stored matrix.
// Shared with the matching deserializer, which uses the same indexing.
// Ports:
//   i_matrix : N*K elements of WIDTH bits, element index r*K+c
//   i_count  : beat index
//   o_beat   : BEAT_SIZE elements, o_beat[e] = i_matrix[i_count*BEAT_SIZE+e]
// ----------------------------------------------------------------------------
module serializer_beat_mux #(
   parameter int N         = 2,
   parameter int K         = 2,
   parameter int WIDTH     = 16,
   parameter int BEAT_SIZE = 2,
   parameter int CNT_W     = 1
) (
   input  logic [N*K-1:0][WIDTH-1:0]       i_matrix,
   input  logic [CNT_W-1:0]                i_count,
   output logic [BEAT_SIZE-1:0][WIDTH-1:0] o_beat
);

   // AND-OR selection over constant indices keeps every array index static.
   always_comb begin
      o_beat = '0;
      for (int e = 0; e < BEAT_SIZE; e++) begin
         for (int m = 0; m < N * K; m++) begin
            o_beat[e] = o_beat[e] |
                        ((m == (int'(i_count) * BEAT_SIZE) + e) ? i_matrix[m] : {WIDTH{1'b0}});
         end
      end
   end

endmodule

// File: rtl/matrix_stream_serializer.sv
// ----------------------------------------------------------------------------
// matrix_stream_serializer
// Accepts one complete N x K matrix in parallel (valid/ready) and replays it
// as a row-major stream of BEAT_SIZE elements per beat, flagging the final
// beat with o_out_last. Data passes through unmodified.
//
// Optional build macro: SERIALIZER_PREFETCH_EN
//   Adds a one-matrix holding register so the next matrix can be accepted
//   while the current one is streaming, removing the idle bubble between
//   back-to-back matrices. Without it the block accepts only when idle.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_in_data      : N*K elements of WIDTH bits, row-major (index r*K+c)
//   i_in_valid     : matrix valid
//   o_in_ready     : matrix accepted when i_in_valid && o_in_ready
//   o_out_data     : current beat, BEAT_SIZE elements
//   o_out_valid    : beat valid
//   i_out_ready    : beat accepted when o_out_valid && i_out_ready
//   o_out_last     : high on the final beat of a matrix
// ----------------------------------------------------------------------------
module matrix_stream_serializer
   import matrix_stream_pkg::*;
#(
   parameter int N         = 2,
   parameter int K         = 2,
   parameter int WIDTH     = 16,
   parameter int BEAT_SIZE = 2
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [N*K-1:0][WIDTH-1:0]       i_in_data,
   input  logic                            i_in_valid,
   output logic                            o_in_ready,
   output logic [BEAT_SIZE-1:0][WIDTH-1:0] o_out_data,
   output logic                            o_out_valid,
   input  logic                            i_out_ready,
   output logic                            o_out_last
);

   localparam int NUM_BEATS = num_beats(N, K, BEAT_SIZE);
   localparam int CNT_W     = cnt_width(NUM_BEATS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BEATS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   generate
      if (((N * K) % BEAT_SIZE) != 0) begin : g_bad_beat_size
         $fatal(1, "matrix_stream_serializer: BEAT_SIZE must divide N*K");
      end
   endgenerate

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic [CNT_W-1:0]            r_count;
   logic [CNT_W-1:0]            w_count_nxt;
   logic [N*K-1:0][WIDTH-1:0]   r_matrix;
   logic [N*K-1:0][WIDTH-1:0]   w_matrix_nxt;
   logic                        w_last;
   logic                        w_in_fire;
   logic                        w_out_fire;

`ifdef SERIALIZER_PREFETCH_EN
   logic [N*K-1:0][WIDTH-1:0]   r_hold;
   logic [N*K-1:0][WIDTH-1:0]   w_hold_nxt;
   logic                        r_hold_full;
   logic                        w_hold_full_nxt;

   // A free holding slot is the only acceptance condition, also while idle.
   assign o_in_ready = !r_hold_full;
`else
   assign o_in_ready = (r_state == IDLE);
`endif

   // Outputs depend only on registered state, never on i_out_ready.
   assign o_out_valid = (r_state == SEND);
   assign w_last      = (r_count == CNT_LAST);
   assign o_out_last  = o_out_valid && w_last;
   assign w_in_fire   = i_in_valid && o_in_ready;
   assign w_out_fire  = o_out_valid && i_out_ready;

   serializer_beat_mux #(
      .N         (N),
      .K         (K),
      .WIDTH     (WIDTH),
      .BEAT_SIZE (BEAT_SIZE),
      .CNT_W     (CNT_W)
   ) u_beat_mux (
      .i_matrix (r_matrix),
      .i_count  (r_count),
      .o_beat   (o_out_data)
   );

   // Next-state, beat counter and matrix/hold register updates.
   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_matrix_nxt = r_matrix;
`ifdef SERIALIZER_PREFETCH_EN
      w_hold_nxt      = r_hold;
      w_hold_full_nxt = r_hold_full;
`endif
      case (r_state)
         IDLE: begin
            if (w_in_fire) begin
               w_matrix_nxt = i_in_data;
               w_count_nxt  = '0;
               w_state_nxt  = SEND;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SEND: begin
`ifdef SERIALIZER_PREFETCH_EN
            if (w_out_fire && w_last) begin
               w_count_nxt = '0;
               // Hold slot first; o_in_ready is low when it is full, so no
               // new matrix can arrive in the same cycle in that case.
               if (r_hold_full) begin
                  w_matrix_nxt    = r_hold;
                  w_hold_full_nxt = 1'b0;
               end else if (w_in_fire) begin
                  w_matrix_nxt = i_in_data;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               if (w_out_fire) begin
                  w_count_nxt = r_count + CNT_ONE;
               end else begin
                  w_count_nxt = r_count;
               end
               if (w_in_fire) begin
                  w_hold_nxt      = i_in_data;
                  w_hold_full_nxt = 1'b1;
               end else begin
                  w_hold_full_nxt = r_hold_full;
               end
            end
`else
            if (w_out_fire) begin
               if (w_last) begin
                  w_count_nxt = '0;
                  w_state_nxt = IDLE;
               end else begin
                  w_count_nxt = r_count + CNT_ONE;
               end
            end else begin
               w_count_nxt = r_count;
            end
`endif
         end
         default: begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
         end
      endcase
   end

   // Controller and matrix register; reset abandons any partial stream.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_matrix <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_matrix <= w_matrix_nxt;
      end
   end

`ifdef SERIALIZER_PREFETCH_EN
   // Prefetch holding register and its occupancy flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else begin
         r_hold      <= w_hold_nxt;
         r_hold_full <= w_hold_full_nxt;
      end
   end
`endif

endmodule
